// File: rtl/bus_target_mem_pkg.sv
// Shared types for the ALE/AD bus target: cycle state, transfer direction, wait-state ceiling.
// No logic; latency and backpressure n/a.
package bus_target_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        XFER = 2'd3
    } state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } dir_e;

    localparam int unsigned MAX_WAIT = 15;

endpackage

// File: rtl/bus_target_mem_array.sv
// Byte store behind the bus target: synchronous write, registered read of the addressed word.
// Latency: rdata_o reflects addr_i one clock later; no backpressure.
module target_mem_array #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    output logic [DATA_W-1:0]    rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/bus_target_mem.sv
// Memory/IO window target on the multiplexed ALE/AD bus; flags illegal strobe combinations.
// Latency: read data on AD 2+WAIT_STATES clocks after the ALE edge; READY low WAIT_STATES cycles.
module bus_target_mem
    import bus_target_mem_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 20,
    parameter int unsigned       DATA_W      = 8,
    parameter bit                IOorM       = 1'b1,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       SIZE_LOG2   = 10,
    parameter int unsigned       WAIT_STATES = 0
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     ALE,
    input  logic                     IOM,
    input  logic                     CS,
    input  logic                     RD_N,
    input  logic                     WR_N,
    input  logic [ADDR_W-DATA_W-1:0] A,
    inout  wire  [DATA_W-1:0]        AD,
    output logic                     READY,
    output logic                     BUS_ERR
);

    localparam int unsigned       CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << SIZE_LOG2) - 64'd1);
    localparam logic [ADDR_W-1:0] BASE_TAG = BASE_ADDR >> SIZE_LOG2;

    if ((BASE_ADDR & OFS_MASK) != '0) begin : g_chk_base
        $error("bus_target_mem: BASE_ADDR not aligned to 2**SIZE_LOG2");
    end
    if (WAIT_STATES > MAX_WAIT) begin : g_chk_wait
        $error("bus_target_mem: WAIT_STATES exceeds MAX_WAIT");
    end
    if (SIZE_LOG2 < 1 || SIZE_LOG2 > ADDR_W) begin : g_chk_size
        $error("bus_target_mem: SIZE_LOG2 out of range");
    end

    logic [ADDR_W-1:0]    addr;
    logic                 hit;
    logic                 both_low;
    logic                 strobe_on;
    logic                 we;
    logic [DATA_W-1:0]    rdata;

    state_e               state_q;
    dir_e                 dir_q;
    logic [SIZE_LOG2-1:0] offset_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 ready_q;
    logic                 err_q;
    logic                 oe_q;
    logic                 wr_done_q;

    assign addr      = {A, AD};
    assign hit       = CS && ALE && (IOM == IOorM) && ((addr >> SIZE_LOG2) == BASE_TAG);
    assign both_low  = !RD_N && !WR_N;
    assign strobe_on = (dir_q == RD) ? !RD_N : !WR_N;

    // Only the first XFER edge of a write commits; later edges with WR_N still low are ignored.
    assign we = (state_q == XFER) && (dir_q == WR) && !ALE && !WR_N && RD_N && !wr_done_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            dir_q     <= RD;
            offset_q  <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            oe_q      <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (ALE) begin
                // A new address phase always wins, abandoning whatever cycle was in flight.
                oe_q      <= 1'b0;
                ready_q   <= 1'b1;
                cnt_q     <= '0;
                wr_done_q <= 1'b0;
                if (hit) begin
                    state_q  <= ADDR;
                    offset_q <= addr[SIZE_LOG2-1:0];
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    ADDR: begin
                        if (both_low) begin
                            state_q <= IDLE;
                            err_q   <= 1'b1;
                        end else if (!RD_N || !WR_N) begin
                            dir_q <= RD_N ? WR : RD;
                            if (WAIT_STATES == 0) begin
                                state_q <= XFER;
                            end else begin
                                state_q <= WAIT;
                                cnt_q   <= CNT_W'(WAIT_STATES);
                                ready_q <= 1'b0;
                            end
                        end
                    end
                    WAIT: begin
                        if (both_low || !strobe_on) begin
                            state_q <= IDLE;
                            err_q   <= both_low;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(1)) begin
                            state_q <= XFER;
                            ready_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    XFER: begin
                        if (both_low || !strobe_on) begin
                            state_q <= IDLE;
                            err_q   <= both_low;
                            oe_q    <= 1'b0;
                        end else if (dir_q == RD) begin
                            oe_q <= 1'b1;
                        end else begin
                            wr_done_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    target_mem_array #(
        .DATA_W    (DATA_W),
        .ADDR_BITS (SIZE_LOG2)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (we),
        .addr_i  (offset_q),
        .wdata_i (AD),
        .rdata_o (rdata)
    );

    assign AD      = oe_q ? rdata : {DATA_W{1'bz}};
    assign READY   = ready_q;
    assign BUS_ERR = err_q;

endmodule
